ultra_sensor_ctrl: RTL and testbench
====================================

Name: ultra_sensor_ctrl

Overview:
Measurement controller for the HC-SR04 ultrasonic sensor. It sits directly downstream of the 1 us tick generator and consumes its tick. It also drives that generator's run/clear inputs.
Per measurement it issues the trigger pulse, times the echo pulse in microseconds, converts the result to centimetres and presents it with a valid strobe. A timeout path covers a missing or stuck echo.

Parameters:
TRIG_US, 10, trigger high time in 1 us ticks
TIMEOUT_US, 30000, maximum ticks from trigger end to echo fall, covering wait plus measure
US_PER_CM, 58, echo microseconds per centimetre of distance
DIST_W, 10, width of distance result; counter saturates at 2^DIST_W-1

Ports:
iClk  in  1  system clock (100 MHz)
iRst  in  1  asynchronous, active-high reset
iTick_1us  in  1  one-iClk-wide pulse every 1 us from the tick generator
iStart  in  1  measurement request pulse; honoured only in IDLE
iEcho  in  1  raw sensor echo, asynchronous
oRun  out  1  run enable to the tick generator
oClear  out  1  one-cycle clear to the tick generator
oTrig  out  1  sensor trigger
oBusy  out  1  high whenever state is not IDLE
oDist  out  DIST_W  last valid distance in cm
oValid  out  1  one-cycle strobe when oDist updates
oError  out  1  timeout flag

Behaviour:
- Reset (async, iRst=1): state IDLE. oRun=0, oClear=0, oTrig=0, oBusy=0, oDist=0, oValid=0, oError=0. All counters and sync flops cleared.
- Echo sync: iEcho passes through a 2-FF synchroniser, then a third flop for edge detect. Rise and fall are each detected one cycle after the synced level changes. The FSM uses synced signals only.
- All outputs are registered.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE.
- IDLE:
  - iStart=1 -> TRIG on the next edge.
  - In that same edge: oClear=1 for one cycle, oError cleared to 0, tick/cm/timeout counters zeroed.
  - iStart in any other state is ignored (no queueing).
- TRIG:
  - oTrig=1, oRun=1.
  - Counts iTick_1us. On the TRIG_US-th tick -> WAIT_ECHO, with oTrig=0 from the following cycle.
- WAIT_ECHO:
  - oRun=1. Timeout counter increments per tick.
  - Synced echo rising edge -> MEASURE.
  - Echo already high on entry is not a rising edge; a stuck-high echo therefore times out.
- MEASURE:
  - oRun=1. Sub-counter counts ticks 0..US_PER_CM-1.
  - On wrap, the cm counter increments; it saturates at all-ones and never wraps to 0.
  - Timeout counter keeps running.
  - Synced echo falling edge -> DONE.
- DONE (exactly one cycle):
  - oDist <= cm counter; oValid=1 in this cycle only.
  - Partial centimetre is truncated (floor of echo_us/US_PER_CM).
  - Then -> IDLE.
- Timeout: in WAIT_ECHO or MEASURE, when the timeout counter reaches TIMEOUT_US -> IDLE.
  - oError=1 and stays high until the next accepted iStart.
  - oDist unchanged; oValid not asserted.
- Tick and echo edge in the same cycle: the echo edge is processed first (state change). That tick is still counted in the old state for MEASURE. Echo fall and timeout in the same cycle: the fall wins (valid result, no error).
- oRun=0 in IDLE and DONE. oBusy = (state != IDLE).
- Reset mid-operation: immediate return to reset values. oTrig drops asynchronously; no oValid is emitted.
- Latency: echo fall on pin -> oValid high in 4 iClk cycles (3 sync/edge flops + DONE register).

Test Plan:
- Reset mid-TRIG at tick 5 -> oTrig=0 immediately; all outputs at reset values; next iStart runs normally.
- iStart, echo rises 200 us after trigger, high for 580 us -> oTrig high exactly 10 ticks; oValid one cycle; oDist=10; oError=0; oValid 4 cycles after echo fall.
- Echo high 57 us -> oDist=0 with oValid. Echo 116 us -> oDist=2. Echo 115 us -> oDist=1 (floor check).
- TIMEOUT_US=1000, echo never rises -> back to IDLE at tick 1000 after trigger end; oError=1; oDist keeps prior value 10; next iStart clears oError.
- Echo held high from before trigger (TIMEOUT_US=1000) -> no MEASURE entry; timeout; oError=1.
- DIST_W=4, echo 1200 us -> oDist=15 (saturated). iStart pulses during MEASURE are ignored; oBusy=1 throughout; exactly one oValid.

Source files
------------

// File: rtl/ultra_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ultra_sensor_ctrl
//  Description : HC-SR04 measurement controller. Issues the trigger pulse,
//                times the echo in 1 us ticks, converts to centimetres and
//                presents the result with a valid strobe. Times out on a
//                missing or stuck echo.
//  Revision    : 1.0 - initial release
// ============================================================================
module ultra_sensor_ctrl #(
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int US_PER_CM  = 58,
    parameter int DIST_W     = 10
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iTick_1us,
    input  logic              iStart,
    input  logic              iEcho,
    output logic              oRun,
    output logic              oClear,
    output logic              oTrig,
    output logic              oBusy,
    output logic [DIST_W-1:0] oDist,
    output logic              oValid,
    output logic              oError
);

    // Counter widths sized to hold their terminal values
    localparam int c_TRIG_W = $clog2(TRIG_US + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_US + 1);
    localparam int c_SUB_W  = $clog2(US_PER_CM + 1);

    localparam logic [c_TRIG_W-1:0] c_TRIG_LAST = c_TRIG_W'(TRIG_US - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_US - 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX    = c_TO_W'(TIMEOUT_US);
    localparam logic [c_SUB_W-1:0]  c_SUB_LAST  = c_SUB_W'(US_PER_CM - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_MEAS = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_TRIG_W-1:0] r_trigCnt;
    logic [c_TO_W-1:0]   r_toCnt;
    logic [c_SUB_W-1:0]  r_subCnt;
    logic [DIST_W-1:0]   r_cmCnt;

    logic r_echoMeta;
    logic r_echoSync;
    logic r_echoDly;

    logic w_echoRise;
    logic w_echoFall;
    logic w_toHit;

    // Two-flop synchroniser for the raw echo plus a delay flop for edges
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_echoMeta <= 1'b0;
            r_echoSync <= 1'b0;
            r_echoDly  <= 1'b0;
        end else begin
            r_echoMeta <= iEcho;
            r_echoSync <= r_echoMeta;
            r_echoDly  <= r_echoSync;
        end
    end

    assign w_echoRise = r_echoSync & ~r_echoDly;
    assign w_echoFall = ~r_echoSync & r_echoDly;
    // The counter may sit at TIMEOUT_US if a rise won against the final tick,
    // so compare with >= to guarantee the timeout still fires afterwards.
    assign w_toHit    = iTick_1us && (r_toCnt >= c_TO_LAST);

    // Measurement FSM with all outputs registered alongside the state
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_trigCnt <= '0;
            r_toCnt   <= '0;
            r_subCnt  <= '0;
            r_cmCnt   <= '0;
            oRun      <= 1'b0;
            oClear    <= 1'b0;
            oTrig     <= 1'b0;
            oBusy     <= 1'b0;
            oDist     <= '0;
            oValid    <= 1'b0;
            oError    <= 1'b0;
        end else begin
            oClear <= 1'b0;
            oValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_state   <= S_TRIG;
                        r_trigCnt <= '0;
                        r_toCnt   <= '0;
                        r_subCnt  <= '0;
                        r_cmCnt   <= '0;
                        oClear    <= 1'b1;
                        oError    <= 1'b0;
                        oTrig     <= 1'b1;
                        oRun      <= 1'b1;
                        oBusy     <= 1'b1;
                    end
                end

                S_TRIG: begin
                    if (iTick_1us) begin
                        if (r_trigCnt == c_TRIG_LAST) begin
                            r_state <= S_WAIT;
                            oTrig   <= 1'b0;
                        end else begin
                            r_trigCnt <= r_trigCnt + 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    if (iTick_1us && (r_toCnt != c_TO_MAX)) begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                    // Only a rise seen inside this state counts; an echo that
                    // was already high on entry leads to a timeout.
                    if (w_echoRise) begin
                        r_state <= S_MEAS;
                    end else if (w_toHit) begin
                        r_state <= S_IDLE;
                        oError  <= 1'b1;
                        oRun    <= 1'b0;
                        oBusy   <= 1'b0;
                    end
                end

                S_MEAS: begin
                    if (iTick_1us) begin
                        if (r_toCnt != c_TO_MAX) begin
                            r_toCnt <= r_toCnt + 1'b1;
                        end
                        if (r_subCnt == c_SUB_LAST) begin
                            r_subCnt <= '0;
                            if (r_cmCnt != {DIST_W{1'b1}}) begin
                                r_cmCnt <= r_cmCnt + 1'b1;
                            end
                        end else begin
                            r_subCnt <= r_subCnt + 1'b1;
                        end
                    end
                    // A fall in the same cycle as the timeout yields a result
                    if (w_echoFall) begin
                        r_state <= S_DONE;
                        oRun    <= 1'b0;
                    end else if (w_toHit) begin
                        r_state <= S_IDLE;
                        oError  <= 1'b1;
                        oRun    <= 1'b0;
                        oBusy   <= 1'b0;
                    end
                end

                S_DONE: begin
                    // cm counter already includes any tick from the fall cycle
                    oDist   <= r_cmCnt;
                    oValid  <= 1'b1;
                    r_state <= S_IDLE;
                    oBusy   <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    oTrig   <= 1'b0;
                    oRun    <= 1'b0;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultra_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ultra_sensor_ctrl
//  Description : Directed self-checking bench for ultra_sensor_ctrl. Instance
//                A uses a short timeout, instance B a 4-bit distance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ultra_sensor_ctrl;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tick   = 1'b0;
    logic       startA = 1'b0;
    logic       echoA  = 1'b0;
    logic       startB = 1'b0;
    logic       echoB  = 1'b0;
    int         divCnt = 0;

    logic       oRunA, oClearA, oTrigA, oBusyA, oValidA, oErrorA;
    logic [9:0] oDistA;
    logic       oRunB, oClearB, oTrigB, oBusyB, oValidB, oErrorB;
    logic [3:0] oDistB;

    int nChecks = 0;
    int nFails  = 0;

    ultra_sensor_ctrl #(.TIMEOUT_US(1000)) uA (
        .iClk(clk), .iRst(rst), .iTick_1us(tick), .iStart(startA), .iEcho(echoA),
        .oRun(oRunA), .oClear(oClearA), .oTrig(oTrigA), .oBusy(oBusyA),
        .oDist(oDistA), .oValid(oValidA), .oError(oErrorA)
    );

    ultra_sensor_ctrl #(.DIST_W(4)) uB (
        .iClk(clk), .iRst(rst), .iTick_1us(tick), .iStart(startB), .iEcho(echoB),
        .oRun(oRunB), .oClear(oClearB), .oTrig(oTrigB), .oBusy(oBusyB),
        .oDist(oDistB), .oValid(oValidB), .oError(oErrorB)
    );

    always #5 clk = ~clk;

    // 1 us tick scaled to one pulse every 10 clocks
    always @(posedge clk) begin
        divCnt <= (divCnt == 9) ? 0 : divCnt + 1;
        tick   <= (divCnt == 8);
    end

    task automatic pulseStartA();
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
    endtask

    task automatic pulseStartB();
        @(negedge clk); startB = 1'b1;
        @(negedge clk); startB = 1'b0;
    endtask

    // Runs one measurement on instance A; returns trigger ticks and fall->valid latency
    task automatic runEchoA(input int delayUs, input int highUs,
                            output int trigTicks, output int lat, output bit ok);
        int guard;
        ok = 1'b1;
        pulseStartA();
        trigTicks = 0;
        guard = 0;
        while (oTrigA === 1'b1 && guard < 1000) begin
            if (tick) trigTicks++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) ok = 1'b0;
        repeat (delayUs * 10) @(negedge clk);
        echoA = 1'b1;
        repeat (highUs * 10) @(negedge clk);
        echoA = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (oValidA !== 1'b1 && lat < 50);
    endtask

    task automatic test_reset();
        int nt;
        int guard;
        repeat (3) @(negedge clk);
        nChecks++;
        if ({oRunA, oClearA, oTrigA, oBusyA, oValidA, oErrorA, oDistA} !== 16'd0) begin
            nFails++;
            $display("FAIL reset_A_outputs: got %b expected all zero",
                     {oRunA, oClearA, oTrigA, oBusyA, oValidA, oErrorA, oDistA});
        end
        nChecks++;
        if ({oRunB, oClearB, oTrigB, oBusyB, oValidB, oErrorB, oDistB} !== 10'd0) begin
            nFails++;
            $display("FAIL reset_B_outputs: got %b expected all zero",
                     {oRunB, oClearB, oTrigB, oBusyB, oValidB, oErrorB, oDistB});
        end
        rst = 1'b0;
        pulseStartA();
        nChecks++;
        if (oClearA !== 1'b1 || oTrigA !== 1'b1 || oBusyA !== 1'b1 || oRunA !== 1'b1) begin
            nFails++;
            $display("FAIL start_outputs: got clear=%b trig=%b busy=%b run=%b expected 1 1 1 1",
                     oClearA, oTrigA, oBusyA, oRunA);
        end
        @(negedge clk);
        nChecks++;
        if (oClearA !== 1'b0) begin
            nFails++;
            $display("FAIL clear_one_cycle: got %b expected 0", oClearA);
        end
        nt = 0;
        guard = 0;
        while (nt < 5 && guard < 200) begin
            @(negedge clk);
            if (tick) nt++;
            guard++;
        end
        #3 rst = 1'b1;
        #1;
        nChecks++;
        if (oTrigA !== 1'b0) begin
            nFails++;
            $display("FAIL reset_mid_trig_oTrig: got %b expected 0", oTrigA);
        end
        nChecks++;
        if ({oRunA, oClearA, oBusyA, oValidA, oErrorA, oDistA} !== 15'd0) begin
            nFails++;
            $display("FAIL reset_mid_trig_outputs: got %b expected all zero",
                     {oRunA, oClearA, oBusyA, oValidA, oErrorA, oDistA});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_floor();
        int          hiUs [3];
        logic [9:0]  expCm[3];
        int          trigTicks;
        int          lat;
        bit          ok;
        hiUs  = '{116, 57, 115};
        expCm = '{10'd2, 10'd0, 10'd1};
        for (int i = 0; i < 3; i++) begin
            runEchoA(20, hiUs[i], trigTicks, lat, ok);
            nChecks++;
            if (!ok || trigTicks != 10) begin
                nFails++;
                $display("FAIL floor_trig_ticks[%0d]: got %0d expected 10", i, trigTicks);
            end
            nChecks++;
            if (lat != 4) begin
                nFails++;
                $display("FAIL floor_latency[%0d]: got %0d expected 4", i, lat);
            end
            nChecks++;
            if (oDistA !== expCm[i]) begin
                nFails++;
                $display("FAIL floor_dist[%0d]: got %0d expected %0d", i, oDistA, expCm[i]);
            end
        end
    endtask

    task automatic test_normal();
        int trigTicks;
        int lat;
        bit ok;
        runEchoA(200, 580, trigTicks, lat, ok);
        nChecks++;
        if (!ok || trigTicks != 10) begin
            nFails++;
            $display("FAIL normal_trig_ticks: got %0d expected 10", trigTicks);
        end
        nChecks++;
        if (lat != 4) begin
            nFails++;
            $display("FAIL normal_latency: got %0d expected 4", lat);
        end
        nChecks++;
        if (oDistA !== 10'd10 || oErrorA !== 1'b0) begin
            nFails++;
            $display("FAIL normal_dist: got dist=%0d err=%b expected 10 0", oDistA, oErrorA);
        end
        @(negedge clk);
        nChecks++;
        if (oValidA !== 1'b0 || oBusyA !== 1'b0 || oRunA !== 1'b0) begin
            nFails++;
            $display("FAIL normal_after_valid: got valid=%b busy=%b run=%b expected 0 0 0",
                     oValidA, oBusyA, oRunA);
        end
    endtask

    // Waits out the trigger then counts ticks until the controller goes idle
    task automatic waitTimeoutA(output int waitTicks, output int validSeen, output bit runLow);
        int guard;
        guard = 0;
        while (oTrigA === 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        runLow = (oRunA !== 1'b1);
        waitTicks = 0;
        validSeen = 0;
        guard = 0;
        while (oBusyA === 1'b1 && guard < 20000) begin
            if (tick) waitTicks++;
            if (oValidA) validSeen++;
            if (oRunA !== 1'b1) runLow = 1'b1;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_timeout();
        int waitTicks;
        int validSeen;
        bit runLow;
        pulseStartA();
        waitTimeoutA(waitTicks, validSeen, runLow);
        nChecks++;
        if (waitTicks != 1000) begin
            nFails++;
            $display("FAIL timeout_ticks: got %0d expected 1000", waitTicks);
        end
        nChecks++;
        if (runLow) begin
            nFails++;
            $display("FAIL timeout_run_held: got low expected high while waiting");
        end
        nChecks++;
        if (oErrorA !== 1'b1 || validSeen != 0) begin
            nFails++;
            $display("FAIL timeout_error: got err=%b valids=%0d expected 1 0", oErrorA, validSeen);
        end
        nChecks++;
        if (oDistA !== 10'd10 || oRunA !== 1'b0) begin
            nFails++;
            $display("FAIL timeout_dist_kept: got dist=%0d run=%b expected 10 0", oDistA, oRunA);
        end
    endtask

    task automatic test_stuck_high();
        int waitTicks;
        int validSeen;
        bit runLow;
        echoA = 1'b1;
        repeat (20) @(negedge clk);
        pulseStartA();
        nChecks++;
        if (oErrorA !== 1'b0) begin
            nFails++;
            $display("FAIL error_cleared_on_start: got %b expected 0", oErrorA);
        end
        waitTimeoutA(waitTicks, validSeen, runLow);
        nChecks++;
        if (waitTicks != 1000 || validSeen != 0) begin
            nFails++;
            $display("FAIL stuck_timeout: got ticks=%0d valids=%0d expected 1000 0",
                     waitTicks, validSeen);
        end
        nChecks++;
        if (oErrorA !== 1'b1 || oDistA !== 10'd10) begin
            nFails++;
            $display("FAIL stuck_error: got err=%b dist=%0d expected 1 10", oErrorA, oDistA);
        end
        echoA = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_saturate();
        int guard;
        int nValid;
        bit busyDrop;
        pulseStartB();
        guard = 0;
        while (oTrigB === 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (200) @(negedge clk);
        echoB = 1'b1;
        nValid = 0;
        busyDrop = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            if (oBusyB !== 1'b1) busyDrop = 1'b1;
            if (oValidB === 1'b1) nValid++;
            startB = (c % 3000 == 1500);
        end
        startB = 1'b0;
        echoB = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (oValidB === 1'b1) nValid++;
        end
        nChecks++;
        if (busyDrop) begin
            nFails++;
            $display("FAIL sat_busy_held: got busy low expected high throughout");
        end
        nChecks++;
        if (nValid != 1) begin
            nFails++;
            $display("FAIL sat_valid_count: got %0d expected 1", nValid);
        end
        nChecks++;
        if (oDistB !== 4'd15 || oErrorB !== 1'b0) begin
            nFails++;
            $display("FAIL sat_dist: got dist=%0d err=%b expected 15 0", oDistB, oErrorB);
        end
        nChecks++;
        if (oBusyB !== 1'b0) begin
            nFails++;
            $display("FAIL sat_start_ignored: got busy=%b expected 0", oBusyB);
        end
    endtask

    initial begin
        test_reset();
        test_floor();
        test_normal();
        test_timeout();
        test_stuck_high();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
